// File: rtl/bp_fpga_host_pkg.sv
// Shared FPGA-host types: NBF command layout, AXI-Lite register offsets and
// response codes, and the state type used by both AXI-Lite channel FSMs.
package bp_fpga_host_pkg;

    localparam int NBF_OPCODE_W = 8;
    localparam int NBF_ADDR_W   = 64;
    localparam int NBF_DATA_W   = 64;

    typedef struct packed {
        logic [NBF_OPCODE_W-1:0] opcode;
        logic [NBF_ADDR_W-1:0]   addr;
        logic [NBF_DATA_W-1:0]   data;
    } bp_nbf_s;

    // Register offsets within the AXI-Lite window (decoded on bits [4:0]).
    localparam logic [4:0] REG_DATA    = 5'h00;
    localparam logic [4:0] REG_CREDITS = 5'h04;
    localparam logic [4:0] REG_STATUS  = 5'h08;
    localparam logic [4:0] REG_CLEAR   = 5'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Each channel has one transaction in flight at most: idle, or holding a response.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RESP = 1'b1
    } chan_state_e;

endpackage

// File: rtl/bp_axil_nbf_assembler_if.sv
// AXI-Lite bus bundle between the NBF loader (master) and the assembler (slave).
interface bp_axil_nbf_assembler_if #(
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// Small power-of-two FIFO holding assembled NBF commands; exposes occupancy
// so the assembler can report credits. Push is ignored when full, pop when empty.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [width_p-1:0]     push_data,
    output logic                   full,
    input  logic                   pop,
    output logic [width_p-1:0]     pop_data,
    output logic                   empty,
    output logic [$clog2(els_p):0] count
);
    localparam int               PTR_W    = $clog2(els_p);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [PTR_W-1:0]   wptr_r;
    logic [PTR_W-1:0]   rptr_r;
    logic [PTR_W:0]     count_r;
    logic               do_push;
    logic               do_pop;

    assign full     = (count_r == CNT_FULL);
    assign empty    = (count_r == '0);
    assign count    = count_r;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr_r];

    // Storage write port.
    // NOTE: the storage array has no reset; an entry is only observable after it
    // has been written, and the top gates pop_data with empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at els_p.
    // NOTE: clocked blocks use only non-blocking (<=) so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wptr_r <= wptr_r + PTR_ONE;
            if (do_pop)  rptr_r <= rptr_r + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/bp_axil_nbf_assembler.sv
// AXI-Lite slave ingress of the FPGA host: collects five 32-bit DATA writes
// into one NBF command, queues commands in a FIFO, and exposes CREDITS/STATUS
// so the loader can pace itself.
module bp_axil_nbf_assembler
    import bp_fpga_host_pkg::*;
#(
    parameter int                           S_AXIL_ADDR_WIDTH  = 64,
    parameter int                           S_AXIL_DATA_WIDTH  = 32,
    parameter int                           nbf_opcode_width_p = 8,
    parameter int                           nbf_addr_width_p   = 64,
    parameter int                           nbf_data_width_p   = 64,
    parameter logic [S_AXIL_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
    parameter int                           FIFO_ELS           = 8
) (
    input  logic                          s_axil_aclk,
    input  logic                          s_axil_aresetn,
    bp_axil_nbf_assembler_if.slave        s_axil,
    output logic                          nbf_v_o,
    input  logic                          nbf_ready_and_i,
    output logic [nbf_opcode_width_p-1:0] nbf_opcode_o,
    output logic [nbf_addr_width_p-1:0]   nbf_addr_o,
    output logic [nbf_data_width_p-1:0]   nbf_data_o
);
    if (S_AXIL_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("bp_axil_nbf_assembler: S_AXIL_DATA_WIDTH must be 32");
    end
    if (nbf_opcode_width_p != NBF_OPCODE_W || nbf_addr_width_p != NBF_ADDR_W
        || nbf_data_width_p != NBF_DATA_W) begin : g_bad_nbf_width
        $error("bp_axil_nbf_assembler: NBF widths must match bp_nbf_s");
    end
    if (FIFO_ELS < 2 || (FIFO_ELS & (FIFO_ELS - 1)) != 0) begin : g_bad_fifo_els
        $error("bp_axil_nbf_assembler: FIFO_ELS must be a power of 2, >= 2");
    end

    localparam int CNT_W = $clog2(FIFO_ELS) + 1;

    chan_state_e wr_state_r, wr_state_n;
    chan_state_e rd_state_r, rd_state_n;
    logic [2:0]  idx_r;
    logic        err_sticky_r;
    logic [31:0] hold_r [4];
    logic [1:0]  bresp_r;
    logic [1:0]  rresp_r;
    logic [31:0] rdata_r;

    logic [4:0]  wr_off, rd_off;
    logic        wr_is_data, wr_strb_ok, wr_is_push, wr_err, wr_accept;
    logic        rd_accept, rd_err;
    logic [31:0] rd_value;

    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    bp_nbf_s          push_cmd, fifo_cmd, nbf_out;

    // Protection bits carry no meaning for this register window.
    logic unused_prot;
    assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

    // Write-side decode. A DATA w4 stalls while the FIFO is full; fullness is
    // the registered value, so a same-cycle pop never frees the slot early.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wr_off     = 5'(s_axil.awaddr - BASE_ADDR);
        wr_is_data = (wr_off == REG_DATA);
        wr_strb_ok = (s_axil.wstrb == 4'hF);
        wr_is_push = wr_is_data && wr_strb_ok && (idx_r == 3'd4);
        wr_err     = !(wr_is_data && wr_strb_ok) && (wr_off != REG_CLEAR);
        wr_accept  = s_axil_aresetn && (wr_state_r == CH_IDLE)
                     && s_axil.awvalid && s_axil.wvalid
                     && !(wr_is_push && fifo_full);
    end

    assign s_axil.awready = wr_accept;
    assign s_axil.wready  = wr_accept;
    assign s_axil.bvalid  = (wr_state_r == CH_RESP);
    assign s_axil.bresp   = bresp_r;

    // Write channel next state: respond after acceptance, release on bready.
    always_comb begin
        wr_state_n = wr_state_r;
        case (wr_state_r)
            CH_IDLE: if (wr_accept)     wr_state_n = CH_RESP;
            CH_RESP: if (s_axil.bready) wr_state_n = CH_IDLE;
            default:                    wr_state_n = CH_IDLE;
        endcase
    end

    // Read-side decode; the value is captured at AR acceptance.
    always_comb begin
        rd_off   = 5'(s_axil.araddr - BASE_ADDR);
        rd_value = '0;
        rd_err   = 1'b0;
        case (rd_off)
            REG_CREDITS: rd_value = 32'(FIFO_ELS) - 32'(fifo_count);
            REG_STATUS:  rd_value = {27'b0, err_sticky_r, idx_r};
            default:     rd_err   = 1'b1;
        endcase
    end

    assign s_axil.arready = s_axil_aresetn && (rd_state_r == CH_IDLE);
    assign rd_accept      = s_axil.arready && s_axil.arvalid;
    assign s_axil.rvalid  = (rd_state_r == CH_RESP);
    assign s_axil.rresp   = rresp_r;
    assign s_axil.rdata   = rdata_r;

    // Read channel next state: respond after acceptance, release on rready.
    always_comb begin
        rd_state_n = rd_state_r;
        case (rd_state_r)
            CH_IDLE: if (rd_accept)     rd_state_n = CH_RESP;
            CH_RESP: if (s_axil.rready) rd_state_n = CH_IDLE;
            default:                    rd_state_n = CH_IDLE;
        endcase
    end

    // State registers for both channel FSMs.
    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            wr_state_r <= CH_IDLE;
            rd_state_r <= CH_IDLE;
        end else begin
            wr_state_r <= wr_state_n;
            rd_state_r <= rd_state_n;
        end
    end

    // Write datapath: word index, holding registers, sticky error, B response.
    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            idx_r        <= '0;
            err_sticky_r <= 1'b0;
            bresp_r      <= RESP_OKAY;
            for (int i = 0; i < 4; i++) hold_r[i] <= '0;
        end else if (wr_accept) begin
            bresp_r <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (wr_is_data && !wr_strb_ok) begin
                err_sticky_r <= 1'b1;
            end else if (wr_is_push) begin
                idx_r <= '0;
            end else if (wr_is_data) begin
                hold_r[idx_r[1:0]] <= s_axil.wdata;
                idx_r              <= idx_r + 3'd1;
            end else if (wr_off == REG_CLEAR) begin
                idx_r        <= '0;
                err_sticky_r <= 1'b0;
            end
        end
    end

    // Read datapath: capture data and response at AR acceptance.
    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            rdata_r <= '0;
            rresp_r <= RESP_OKAY;
        end else if (rd_accept) begin
            rdata_r <= rd_value;
            rresp_r <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // w4 carries the opcode in its low byte; the other four words come from holding regs.
    assign push_cmd = {s_axil.wdata[7:0], hold_r[3], hold_r[2], hold_r[1], hold_r[0]};

    bsg_fifo_1r1w_small #(
        .width_p ($bits(bp_nbf_s)),
        .els_p   (FIFO_ELS)
    ) cmd_fifo (
        .clk       (s_axil_aclk),
        .rst_n     (s_axil_aresetn),
        .push      (wr_accept && wr_is_push),
        .push_data (push_cmd),
        .full      (fifo_full),
        .pop       (nbf_v_o && nbf_ready_and_i),
        .pop_data  (fifo_cmd),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs read as zero whenever no command is presented.
    assign nbf_v_o      = !fifo_empty;
    assign nbf_out      = fifo_empty ? '0 : fifo_cmd;
    assign nbf_opcode_o = nbf_out.opcode;
    assign nbf_addr_o   = nbf_out.addr;
    assign nbf_data_o   = nbf_out.data;
endmodule
